// File: rtl/level_meter_if.sv
// Frame bus into the level meter: sample strobe, 8x24 frame, status back.
// master drives frames; slave is the meter reporting busy and drop count.
interface level_meter_if;
  logic             sample_valid;
  logic [7:0][23:0] audio_bus;
  logic             busy;
  logic [7:0]       missed;

  modport master (
    output sample_valid, audio_bus,
    input  busy, missed
  );

  modport slave (
    input  sample_valid, audio_bus,
    output busy, missed
  );
endinterface

// File: rtl/level_meter.sv
// 8-channel peak meter: hold/decay peaks, sticky clip, led bargraph.
// Ports: clk, rst (async low), bus (frame in), channel_sel, clip_clear,
//        peak (8x24), led (8), clip (8).
module level_meter #(
  parameter int HOLD_FRAMES = 24000,
  parameter int DECAY_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  level_meter_if.slave     bus,
  input  logic [2:0]       channel_sel,
  input  logic             clip_clear,
  output logic [7:0][23:0] peak,
  output logic [7:0]       led,
  output logic [7:0]       clip
);

  localparam int HW = (HOLD_FRAMES > 0) ?
    $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
  localparam logic [22:0] FS = 23'h7f_ffff;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHOW
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          ch_idx;
  logic [7:0][23:0]    frame;
  logic [7:0][HW-1:0]  hold;
  logic [7:0]          missed;

  logic [23:0]         cur;
  logic [22:0]         neg;
  logic [22:0]         mag;
  logic [23:0]         pk;
  logic [23:0]         decay;
  logic [23:0]         pk_nxt;
  logic [HW-1:0]       hd;
  logic [HW-1:0]       hd_nxt;
  logic [23:0]         sel_pk;
  logic [7:0]          led_nxt;
  logic [7:0]          clip_nxt;
  logic                scan;
  logic                take;
  logic                drop;

  assign scan = (state == SCAN);
  assign take = (state == IDLE) && bus.sample_valid;
  assign drop = (state != IDLE) && bus.sample_valid;

  assign bus.busy   = (state != IDLE);
  assign bus.missed = missed;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.sample_valid) state_nxt = SCAN;
      SCAN:    if (ch_idx == 3'd7) state_nxt = SHOW;
      SHOW:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // |x| fits 23 bits except -2^23, which clamps to full scale
  always_comb begin
    cur = frame[ch_idx];
    neg = ~cur[22:0] + 23'd1;
    mag = cur[22:0];
    if (cur == 24'h80_0000) begin
      mag = FS;
    end else if (cur[23]) begin
      mag = neg;
    end
  end

  always_comb begin
    pk     = peak[ch_idx];
    hd     = hold[ch_idx];
    decay  = pk >> DECAY_SHIFT;
    pk_nxt = pk;
    hd_nxt = hd;
    if ({1'b0, mag} >= pk) begin
      pk_nxt = {1'b0, mag};
      hd_nxt = HOLD_INIT;
    end else if (hd != '0) begin
      hd_nxt = hd - HW'(1);
    end else if (decay == '0) begin
      pk_nxt = '0;
    end else begin
      pk_nxt = pk - decay;
    end
  end

  // a set in the same cycle as clear wins
  always_comb begin
    clip_nxt = clip;
    if (clip_clear) clip_nxt = '0;
    if (scan && (mag == FS)) clip_nxt[ch_idx] = 1'b1;
  end

  always_comb begin
    sel_pk  = peak[channel_sel];
    led_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      led_nxt[i] = (sel_pk >= (24'd1 << (15 + i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_idx <= '0;
      frame  <= '0;
      peak   <= '0;
      hold   <= '0;
      clip   <= '0;
      led    <= '0;
      missed <= '0;
    end else begin
      if (take) begin
        frame  <= bus.audio_bus;
        ch_idx <= '0;
      end else if (scan) begin
        ch_idx <= ch_idx + 3'd1;
      end
      if (scan) begin
        peak[ch_idx] <= pk_nxt;
        hold[ch_idx] <= hd_nxt;
      end
      if (state == SHOW) begin
        led <= led_nxt;
      end
      clip <= clip_nxt;
      if (drop && (missed != 8'hff)) begin
        missed <= missed + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_level_meter.sv
// Bench for level_meter: directed vectors, decay table, random vs model.
// Runs with HOLD_FRAMES=2, DECAY_SHIFT=2.
module tb_level_meter;

  localparam int HF = 2;
  localparam int DS = 2;
  localparam int NV = 27;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       channel_sel = '0;
  logic             clip_clear = 1'b0;
  logic [7:0][23:0] peak;
  logic [7:0]       led;
  logic [7:0]       clip;

  level_meter_if bus ();

  level_meter #(
    .HOLD_FRAMES(HF),
    .DECAY_SHIFT(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .channel_sel(channel_sel),
    .clip_clear(clip_clear),
    .peak(peak),
    .led(led),
    .clip(clip)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int         m_pk [8];
  int         m_hd [8];
  logic [7:0] m_clip;
  int         m_missed;
  logic [7:0] m_led;

  typedef struct {
    logic [23:0] s3;
    int          pk;
    logic [7:0]  ld;
  } vec_t;

  vec_t tbl [NV];
  int   seq_pk [NV] = '{
    1000, 1000, 1000, 750, 563, 423, 318, 239, 180,
    135, 102, 77, 58, 44, 33, 25, 19, 15,
    12, 9, 7, 6, 5, 4, 3, 0, 0
  };

  logic [7:0][23:0] f;
  logic [7:0][23:0] g;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_pk[k] = 0;
      m_hd[k] = 0;
    end
    m_clip   = '0;
    m_missed = 0;
    m_led    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    bus.audio_bus = '0;
    clip_clear = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  // leaves the bench in cycle T+1
  task automatic send(input logic [7:0][23:0] fr);
    bus.sample_valid = 1'b1;
    bus.audio_bus = fr;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  // steps T+1..T+9 with optional overrun strobes; ends at T+10
  task automatic finish_frame(input int ovr_pct);
    logic [31:0] r;
    for (int j = 0; j < 9; j++) begin
      bus.sample_valid = (int'($urandom_range(99)) < ovr_pct);
      if (bus.sample_valid) begin
        for (int k = 0; k < 8; k++) begin
          r = $urandom();
          bus.audio_bus[k] = r[23:0];
        end
        if (m_missed < 255) m_missed++;
      end
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  function automatic int mabs(input logic [23:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    if (s > 8388607) s = 8388607;
    return s;
  endfunction

  task automatic model_frame(input logic [7:0][23:0] fr,
                             input int sel);
    int a;
    for (int k = 0; k < 8; k++) begin
      a = mabs(fr[k]);
      if (a >= m_pk[k]) begin
        m_pk[k] = a;
        m_hd[k] = HF;
      end else if (m_hd[k] > 0) begin
        m_hd[k]--;
      end else if ((m_pk[k] >> DS) == 0) begin
        m_pk[k] = 0;
      end else begin
        m_pk[k] = m_pk[k] - (m_pk[k] >> DS);
      end
      if (a == 8388607) m_clip[k] = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      m_led[i] = (m_pk[sel] >= (1 << (15 + i)));
    end
  endtask

  task automatic check_all(input int it);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rnd%0d peak%0d", it, k),
          64'(peak[k]), 64'(m_pk[k]));
    end
    chk($sformatf("rnd%0d led", it), 64'(led), 64'(m_led));
    chk($sformatf("rnd%0d clip", it), 64'(clip), 64'(m_clip));
    chk($sformatf("rnd%0d missed", it),
        64'(bus.missed), 64'(m_missed));
    chk($sformatf("rnd%0d busy", it), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int v;
    int mode;
    logic [31:0] r;

    for (int i = 0; i < NV; i++) begin
      tbl[i].s3 = (i == 0) ? 24'd1000 : 24'd0;
      tbl[i].pk = seq_pk[i];
      tbl[i].ld = 8'h00;
    end

    bus.sample_valid = 1'b0;
    bus.audio_bus = '0;
    tick();
    tick();

    // reset state
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst peak%0d", k), 64'(peak[k]), 64'd0);
    end
    chk("rst led", 64'(led), 64'd0);
    chk("rst clip", 64'(clip), 64'd0);
    chk("rst missed", 64'(bus.missed), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    tick();

    // latency
    f = '0;
    f[0] = 24'h10_0000;
    channel_sel = 3'd0;
    send(f);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("lat busy T+%0d", j + 1),
          64'(bus.busy), 64'd1);
      chk($sformatf("lat peak0 T+%0d", j + 1), 64'(peak[0]),
          (j == 0) ? 64'd0 : 64'h10_0000);
      if (j == 8) chk("lat led T+9", 64'(led), 64'd0);
      tick();
    end
    chk("lat busy T+10", 64'(bus.busy), 64'd0);
    chk("lat led T+10", 64'(led), 64'h3f);

    // hold then decay table
    do_reset();
    channel_sel = 3'd3;
    for (int i = 0; i < NV; i++) begin
      f = '0;
      f[3] = tbl[i].s3;
      send(f);
      finish_frame(0);
      chk($sformatf("decay%0d peak3", i),
          64'(peak[3]), 64'(tbl[i].pk));
      chk($sformatf("decay%0d led", i),
          64'(led), 64'(tbl[i].ld));
    end

    // full scale and clip clear collision
    do_reset();
    channel_sel = 3'd5;
    f = '0;
    f[5] = 24'h80_0000;
    send(f);
    repeat (5) tick();
    clip_clear = 1'b1;
    chk("fs clip before", 64'(clip[5]), 64'd0);
    tick();
    clip_clear = 1'b0;
    chk("fs clip set wins", 64'(clip[5]), 64'd1);
    repeat (3) tick();
    chk("fs peak5", 64'(peak[5]), 64'h7f_ffff);
    chk("fs led", 64'(led), 64'hff);
    chk("fs busy", 64'(bus.busy), 64'd0);
    tick();
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    chk("fs clip cleared", 64'(clip), 64'd0);
    chk("fs peak5 kept", 64'(peak[5]), 64'h7f_ffff);

    // overrun
    do_reset();
    channel_sel = 3'd1;
    f = '0;
    f[1] = 24'd5000;
    send(f);
    repeat (3) tick();
    g = '0;
    g[1] = 24'd9000;
    bus.sample_valid = 1'b1;
    bus.audio_bus = g;
    tick();
    bus.sample_valid = 1'b0;
    repeat (5) tick();
    chk("ovr missed", 64'(bus.missed), 64'd1);
    chk("ovr peak1", 64'(peak[1]), 64'd5000);
    chk("ovr busy", 64'(bus.busy), 64'd0);
    bus.audio_bus = '0;
    bus.sample_valid = 1'b1;
    repeat (400) tick();
    bus.sample_valid = 1'b0;
    repeat (12) tick();
    chk("ovr saturate", 64'(bus.missed), 64'd255);

    // reset mid frame
    do_reset();
    channel_sel = 3'd0;
    for (int k = 0; k < 8; k++) f[k] = 24'h30_0000;
    send(f);
    finish_frame(0);
    chk("mid led before", 64'(led), 64'h7f);
    send(f);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid peak%0d", k), 64'(peak[k]), 64'd0);
    end
    chk("mid led", 64'(led), 64'd0);
    chk("mid busy", 64'(bus.busy), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    f = '0;
    f[2] = 24'h00_1234;
    send(f);
    tick();
    tick();
    chk("post peak2 T+3", 64'(peak[2]), 64'd0);
    tick();
    chk("post peak2 T+4", 64'(peak[2]), 64'h1234);
    repeat (6) tick();
    chk("post busy T+10", 64'(bus.busy), 64'd0);

    // random frames against the model
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 8; k++) begin
        mode = int'($urandom_range(5));
        r = $urandom();
        case (mode)
          0, 1, 2: f[k] = '0;
          3: begin
            v = int'($urandom_range(4000)) - 2000;
            f[k] = 24'(v);
          end
          4: f[k] = r[23:0];
          default: begin
            if (r[1:0] == 2'd0) f[k] = 24'h80_0000;
            else if (r[1:0] == 2'd1) f[k] = 24'h7f_ffff;
            else if (r[1:0] == 2'd2) f[k] = 24'h80_0001;
            else f[k] = 24'h00_8000;
          end
        endcase
      end
      sel = int'($urandom_range(7));
      channel_sel = 3'(sel);
      send(f);
      model_frame(f, sel);
      finish_frame(25);
      check_all(it);
      if ($urandom_range(3) == 0) begin
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        m_clip = '0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
